// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding imem reads feeding a small {pc, word} FIFO.
// Optional same-cycle ack-to-decoder bypass is enabled by defining IFETCH_BYPASS_EN.
module instruction_fetch #(
  parameter int INSTR_W = 20,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [19:0]        pc,
  input  logic               redirect,
  output logic               pcWrite,
  output logic               imemReq,
  output logic [19:0]        imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instr,
  output logic [19:0]        instrPc,
  input  logic               instrReady
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [19:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [19:0]        pc_mem   [DEPTH];

  logic accept, push, pop, fifo_empty;

  // A word is accepted only from a live request; DRAIN acks are thrown away.
  assign accept     = (state_q == REQ) && imemAck && !redirect;
  assign pcWrite    = accept;
  assign fifo_empty = (count_q == '0);
  assign imemReq    = req_q;
  assign imemAddr   = addr_q;

`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass     = accept && fifo_empty;
  assign push       = accept && !(bypass && instrReady);
  assign instrValid = !fifo_empty || bypass;
  assign instr      = !fifo_empty ? data_mem[rd_ptr_q] : (bypass ? imemData : '0);
  assign instrPc    = !fifo_empty ? pc_mem[rd_ptr_q]   : (bypass ? addr_q   : '0);
`else
  assign push       = accept;
  assign instrValid = !fifo_empty;
  assign instr      = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign instrPc    = fifo_empty ? '0 : pc_mem[rd_ptr_q];
`endif

  assign pop = !fifo_empty && instrReady;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if ((count_q < CNT_W'(DEPTH)) && !redirect) begin
          state_d = REQ;
          addr_d  = pc;
        end
      end
      REQ: begin
        if (imemAck) begin
          // Back-to-back fetch continues at the next sequential address.
          if (!redirect && (count_d < CNT_W'(DEPTH))) begin
            addr_d = addr_q + 20'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imemAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imemData;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

endmodule
